adc_sample_sched: RTL

ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

---
 rtl/adc_sample_sched.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_sched.sv
// -----------------------------------------------------------------------------
// adc_sample_sched
//
// Acquisition scheduler for a serial ADC front-end. After a start pulse the
// front-end is enabled, the first DISCARD conversions are thrown away while the
// ADC settles, and then one sample in every dec_factor is kept and queued in a
// small FIFO for a ready/valid consumer. A stop pulse disables the front-end
// and lets the FIFO drain before returning to idle. Samples that arrive while
// the FIFO is full (and not being popped) are dropped and counted.
//
// Parameters
//   DEPTH    FIFO depth in samples (power of two, 2..16)
//   DISCARD  conversions discarded after each start (0..15)
//
// Optional feature
//   ADC_SCHED_TIMESTAMP_EN  when defined, adds output sample_idx: the index of
//                           the kept sample at the FIFO head (dropped samples
//                           also consume an index).
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active high
//   start        one-cycle pulse, begins acquisition (idle only)
//   stop         one-cycle pulse, ends acquisition (wins over start)
//   dec_factor   keep one sample in dec_factor (0 acts as 1), latched on start
//   adc_data     converted sample
//   adc_strobe   one-cycle pulse, adc_data valid
//   adc_en       front-end enable (settle and run phases)
//   out_data     FIFO head sample (0 when out_valid is low)
//   out_valid    FIFO not empty
//   out_ready    consumer accepts out_data
//   busy         scheduler not idle
//   overrun      sticky: a kept sample was dropped since the last start
//   overrun_cnt  number of dropped samples, saturating at 255
//   sample_idx   (optional) index of the head sample, aligned with out_data
// -----------------------------------------------------------------------------
module adc_sample_sched #(
    parameter int DEPTH   = 4,
    parameter int DISCARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  dec_factor,
    input  logic [11:0] adc_data,
    input  logic        adc_strobe,
    output logic        adc_en,
    output logic [11:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        overrun,
    output logic [7:0]  overrun_cnt
`ifdef ADC_SCHED_TIMESTAMP_EN
    ,
    output logic [15:0] sample_idx
`endif
);

    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT  = DEPTH[AW:0];
    localparam logic [4:0]  DISCARD_C = DISCARD[4:0];

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [7:0]    dec_lat;
    logic [7:0]    dec_cnt;
    logic [3:0]    settle_cnt;

    // One-deep staging register: a kept sample enters the FIFO the cycle
    // after its strobe, which is also where the full/overrun decision is made.
    logic          pend_valid;
    logic [11:0]   pend_data;

    logic [11:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;

    logic start_go;
    logic settle_strobe;
    logic run_strobe;
    logic settle_done;
    logic keep;
    logic fifo_full;
    logic push;
    logic pop;
    logic drop;

`ifdef ADC_SCHED_TIMESTAMP_EN
    logic [15:0] idx_cnt;
    logic [15:0] pend_idx;
    logic [15:0] idx_mem [DEPTH];
`endif

    // ------------------------------------------------------------------
    // Qualified events. stop has priority over both start and a strobe in
    // the same cycle; strobes outside SETTLE/RUN are ignored.
    // ------------------------------------------------------------------
    assign start_go      = (state == IDLE) && start && !stop;
    assign settle_strobe = (state == SETTLE) && adc_strobe && !stop;
    assign run_strobe    = (state == RUN) && adc_strobe && !stop;
    assign settle_done   = settle_strobe && (({1'b0, settle_cnt} + 5'd1) == DISCARD_C);
    assign keep          = run_strobe && (dec_cnt == 8'd0);

    // ------------------------------------------------------------------
    // FIFO handshake. A pop in the same cycle frees the slot the pending
    // sample needs, so a full FIFO only drops when nothing is leaving.
    // ------------------------------------------------------------------
    assign out_valid = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = out_valid && out_ready;
    assign push      = pend_valid && (!fifo_full || pop);
    assign drop      = pend_valid && fifo_full && !pop;

    // Gating keeps out_data at zero after reset without resetting the array.
    assign out_data  = out_valid ? mem[rd_ptr] : 12'd0;

`ifdef ADC_SCHED_TIMESTAMP_EN
    assign sample_idx = out_valid ? idx_mem[rd_ptr] : 16'd0;
`endif

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + {{AW{1'b0}}, 1'b1};
        end else if (pop && !push) begin
            count_nxt = count - {{AW{1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of its neighbours regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default on entry so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        adc_en    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_go) begin
                    state_nxt = (DISCARD == 0) ? RUN : SETTLE;
                end
            end
            SETTLE: begin
                adc_en = 1'b1;
                if (stop) begin
                    state_nxt = DRAIN;
                end else if (settle_done) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                adc_en = 1'b1;
                if (stop) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                // Leaves as soon as the FIFO empties; with an already empty
                // FIFO this makes DRAIN last exactly one cycle.
                if (count_nxt == '0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Counters, staging register, FIFO pointers and overrun tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_lat     <= 8'd1;
            dec_cnt     <= 8'd0;
            settle_cnt  <= 4'd0;
            pend_valid  <= 1'b0;
            pend_data   <= 12'd0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun     <= 1'b0;
            overrun_cnt <= 8'd0;
`ifdef ADC_SCHED_TIMESTAMP_EN
            idx_cnt     <= 16'd0;
            pend_idx    <= 16'd0;
`endif
        end else begin
            if (start_go) begin
                dec_lat     <= (dec_factor == 8'd0) ? 8'd1 : dec_factor;
                dec_cnt     <= 8'd0;
                settle_cnt  <= 4'd0;
                overrun     <= 1'b0;
                overrun_cnt <= 8'd0;
`ifdef ADC_SCHED_TIMESTAMP_EN
                idx_cnt     <= 16'd0;
`endif
            end

            if (settle_strobe) begin
                settle_cnt <= settle_cnt + 4'd1;
            end

            if (run_strobe) begin
                dec_cnt <= (dec_cnt == dec_lat - 8'd1) ? 8'd0 : dec_cnt + 8'd1;
            end

            pend_valid <= keep;
            if (keep) begin
                pend_data <= adc_data;
`ifdef ADC_SCHED_TIMESTAMP_EN
                pend_idx  <= idx_cnt;
                idx_cnt   <= idx_cnt + 16'd1;
`endif
            end

            // A pending sample only exists in RUN, so this never coincides
            // with the clear on start.
            if (drop) begin
                overrun <= 1'b1;
                if (overrun_cnt != 8'hFF) begin
                    overrun_cnt <= overrun_cnt + 8'd1;
                end
            end

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count and
    // the read side is gated, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pend_data;
`ifdef ADC_SCHED_TIMESTAMP_EN
            idx_mem[wr_ptr] <= pend_idx;
`endif
        end
    end

endmodule
